// File: rtl/mdu_divider.sv
// Iterative restoring divider for DIV/DIVU: one quotient bit per clock,
// returns {remainder, quotient} with truncate-toward-zero sign handling.
module mdu_divider #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   dividend_i,
  input  logic [WIDTH-1:0]   divisor_i,
  input  logic               annul_i,
  output logic               busy_o,
  output logic               ready_o,
  output logic               div_zero_o,
  output logic [2*WIDTH-1:0] result_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   dvd_q, dvd_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic               qneg_q, qneg_d;
  logic               rneg_q, rneg_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               dz_q, dz_d;

  logic               a_neg_s, b_neg_s;
  logic [WIDTH:0]     trial_s;
  logic               qbit_s;
  logic [WIDTH-1:0]   rem_next_s, quo_next_s;

  // Remainder keeps the bit shifted out of its MSB so large divisors still compare correctly.
  assign a_neg_s    = signed_i & dividend_i[WIDTH-1];
  assign b_neg_s    = signed_i & divisor_i[WIDTH-1];
  assign trial_s    = {rem_q, dvd_q[WIDTH-1]} - {1'b0, dvs_q};
  assign qbit_s     = ~trial_s[WIDTH];
  assign rem_next_s = qbit_s ? trial_s[WIDTH-1:0] : {rem_q[WIDTH-2:0], dvd_q[WIDTH-1]};
  assign quo_next_s = {dvd_q[WIDTH-2:0], qbit_s};

  // Next-state and datapath update for the IDLE/CALC/DONE sequencer.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    rem_d    = rem_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    result_d = result_q;
    dz_d     = dz_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (divisor_i == {WIDTH{1'b0}}) begin
            result_d = {dividend_i, {WIDTH{1'b1}}};
            dz_d     = 1'b1;
            state_d  = DONE;
          end else begin
            dvd_d   = a_neg_s ? -dividend_i : dividend_i;
            dvs_d   = b_neg_s ? -divisor_i : divisor_i;
            rem_d   = {WIDTH{1'b0}};
            qneg_d  = a_neg_s ^ b_neg_s;
            rneg_d  = a_neg_s;
            cnt_d   = {CW{1'b0}};
            dz_d    = 1'b0;
            state_d = CALC;
          end
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        if (annul_i) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
          dvd_d = quo_next_s;
          rem_d = rem_next_s;
          if (cnt_q == LAST_CNT) begin
            result_d = {(rneg_q ? -rem_next_s : rem_next_s),
                        (qneg_q ? -quo_next_s : quo_next_s)};
            state_d  = DONE;
          end else begin
            state_d = CALC;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= {CW{1'b0}};
      dvd_q    <= {WIDTH{1'b0}};
      dvs_q    <= {WIDTH{1'b0}};
      rem_q    <= {WIDTH{1'b0}};
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= {(2*WIDTH){1'b0}};
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      rem_q    <= rem_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
      dz_q     <= dz_d;
    end
  end

  assign busy_o     = (state_q == CALC);
  assign ready_o    = (state_q == DONE);
  assign div_zero_o = dz_q;
  assign result_o   = result_q;

endmodule

// File: tb/tb_mdu_divider.sv
// Directed self-checking bench for mdu_divider with hand-computed results.
module tb_mdu_divider;

  localparam int W = 32;

  logic           clk;
  logic           rst;
  logic           start_i;
  logic           signed_i;
  logic [W-1:0]   dividend_i;
  logic [W-1:0]   divisor_i;
  logic           annul_i;
  logic           busy_o;
  logic           ready_o;
  logic           div_zero_o;
  logic [2*W-1:0] result_o;

  int total = 0;
  int bad   = 0;

  mdu_divider #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .signed_i   (signed_i),
    .dividend_i (dividend_i),
    .divisor_i  (divisor_i),
    .annul_i    (annul_i),
    .busy_o     (busy_o),
    .ready_o    (ready_o),
    .div_zero_o (div_zero_o),
    .result_o   (result_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drives a one-cycle request; returns at the first negedge after the start edge.
  task automatic issue(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start_i    = 1'b1;
    signed_i   = sgn;
    dividend_i = a;
    divisor_i  = b;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  // Waits (bounded) for ready_o and checks latency, busy cycles, result and pulse width.
  task automatic wait_done(input string tag, input logic [63:0] exp, input logic exp_dz,
                           input int exp_n);
    int n;
    int busy_cnt;
    n = 0;
    busy_cnt = 0;
    while (!ready_o && n < 100) begin
      if (busy_o) busy_cnt++;
      @(negedge clk);
      n++;
    end
    chk({tag, "_lat"}, 64'(n), 64'(exp_n));
    chk({tag, "_busy"}, 64'(busy_cnt), 64'(exp_n));
    chk({tag, "_res"}, result_o, exp);
    chk({tag, "_dz"}, 64'(div_zero_o), 64'(exp_dz));
    @(negedge clk);
    chk({tag, "_pulse"}, 64'(ready_o), 64'd0);
  endtask

  task automatic run(input string tag, input logic sgn, input logic [W-1:0] a,
                     input logic [W-1:0] b, input logic [63:0] exp, input logic exp_dz,
                     input int exp_n);
    issue(sgn, a, b);
    wait_done(tag, exp, exp_dz, exp_n);
  endtask

  initial begin
    int rdy;
    rst        = 1'b1;
    start_i    = 1'b0;
    signed_i   = 1'b0;
    dividend_i = 32'd0;
    divisor_i  = 32'd0;
    annul_i    = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_ready", 64'(ready_o), 64'd0);
    chk("rst_result", result_o, 64'd0);
    chk("rst_dz", 64'(div_zero_o), 64'd0);
    rst = 1'b0;

    run("divu_100_7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b0, 32);
    run("div_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 1'b0, 32);
    run("div_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE, {32'd1, 32'hFFFFFFFD}, 1'b0, 32);
    run("div_min_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF, {32'd0, 32'h80000000}, 1'b0, 32);
    run("divu_5_0", 1'b0, 32'd5, 32'd0, {32'd5, 32'hFFFFFFFF}, 1'b1, 0);
    run("div_m5_0", 1'b1, 32'hFFFFFFFB, 32'd0, {32'hFFFFFFFB, 32'hFFFFFFFF}, 1'b1, 0);
    run("divu_max_max", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, {32'd0, 32'd1}, 1'b0, 32);
    run("divu_max_big", 1'b0, 32'hFFFFFFFF, 32'h80000001, {32'h7FFFFFFE, 32'd1}, 1'b0, 32);

    // Annul in the middle of CALC: no completion, previous result retained.
    issue(1'b0, 32'd1000, 32'd3);
    repeat (10) @(negedge clk);
    chk("annul_busy_before", 64'(busy_o), 64'd1);
    annul_i = 1'b1;
    @(negedge clk);
    annul_i = 1'b0;
    chk("annul_busy", 64'(busy_o), 64'd0);
    chk("annul_result", result_o, {32'h7FFFFFFE, 32'd1});
    rdy = 0;
    repeat (40) begin
      if (ready_o) rdy++;
      @(negedge clk);
    end
    chk("annul_noready", 64'(rdy), 64'd0);
    run("divu_ffff_10", 1'b0, 32'hFFFFFFFF, 32'h10, {32'hF, 32'h0FFFFFFF}, 1'b0, 32);

    // Start held high: operands change during CALC and are ignored.
    @(negedge clk);
    start_i    = 1'b1;
    signed_i   = 1'b0;
    dividend_i = 32'd100;
    divisor_i  = 32'd7;
    @(negedge clk);
    dividend_i = 32'd50;
    wait_done("held_first", {32'd2, 32'd14}, 1'b0, 32);
    chk("held_idle_busy", 64'(busy_o), 64'd0);
    @(negedge clk);
    chk("held_second_busy", 64'(busy_o), 64'd1);
    start_i = 1'b0;
    wait_done("held_second", {32'd1, 32'd7}, 1'b0, 32);

    // Reset in the middle of CALC discards the operation.
    issue(1'b0, 32'd1000, 32'd3);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_busy", 64'(busy_o), 64'd0);
    chk("mrst_ready", 64'(ready_o), 64'd0);
    chk("mrst_result", result_o, 64'd0);
    rdy = 0;
    repeat (40) begin
      if (ready_o) rdy++;
      @(negedge clk);
    end
    chk("mrst_noready", 64'(rdy), 64'd0);
    run("divu_9_3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 1'b0, 32);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
